// File: rtl/qei_pkg.sv
// qei_pkg: shared types, Gray lookup and step helper for the quadrature encoder emulator.
package qei_pkg;

    typedef logic [1:0] qstate_t;

    typedef enum logic [1:0] {DIR_NONE, DIR_FWD, DIR_REV} dir_e;

    localparam logic [1:0] QEI_GRAY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic qstate_t qei_next(input qstate_t state, input dir_e dir);
        return dir == DIR_FWD ? state + 2'd1 : dir == DIR_REV ? state - 2'd1 : state;
    endfunction

endpackage

// File: rtl/qei_phase_acc.sv
// qei_phase_acc: velocity phase accumulator; a wrap in the direction of travel is one step request.
module qei_phase_acc
    import qei_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [ACC_W-1:0] velocity,
    output logic             step_fwd,
    output logic             step_rev
);

    logic [ACC_W-1:0] acc_q, acc_d, acc_n;

    always_comb begin
        acc_n    = acc_q + velocity;
        acc_d    = enable ? acc_n : acc_q;
        step_fwd = enable && !velocity[ACC_W-1] && (acc_n < acc_q);
        step_rev = enable && velocity[ACC_W-1] && (acc_n > acc_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= '0;
        else          acc_q <= acc_d;
    end

endmodule

// File: rtl/qei_emulator.sv
// qei_emulator: velocity-driven A/B quadrature + index generator with a minimum edge gap.
// Define QEI_EMU_GLITCH_EN to add glitch_req, a one-cycle A-phase noise injector.
module qei_emulator
    import qei_pkg::*;
#(
    parameter int ACC_W   = 32,
    parameter int CPR     = 2000,
    parameter int MIN_GAP = 4,
    parameter int PEND_W  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [ACC_W-1:0]   velocity,
`ifdef QEI_EMU_GLITCH_EN
    input  logic               glitch_req,
`endif
    output logic [1:0]         encab,
    output logic               index,
    output logic signed [31:0] position,
    output logic               overrun,
    input  logic               clr_overrun
);

    localparam int GAP_W  = $clog2(MIN_GAP + 1);
    localparam int REV_W  = $clog2(CPR);
    localparam int PMAX_I = 2 ** (PEND_W - 1) - 1;
    localparam logic signed [PEND_W:0] PMAX = PMAX_I[PEND_W:0];
    localparam logic signed [PEND_W:0] ONE  = {{PEND_W{1'b0}}, 1'b1};

    logic                     step_fwd, step_rev, drop, glitch;
    logic signed [PEND_W-1:0] pend_q, pend_d;
    logic signed [PEND_W:0]   req, sum, emit, net, keep;
    logic [GAP_W-1:0]         gap_q, gap_d;
    logic [REV_W-1:0]         rev_q, rev_d;
    logic signed [31:0]       pos_q, pos_d;
    logic [1:0]               encab_q, encab_d;
    logic                     index_q, index_d, overrun_q, overrun_d;
    qstate_t                  qstate_q, qstate_d;
    dir_e                     dir;

    qei_phase_acc #(.ACC_W(ACC_W)) u_acc (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .velocity (velocity),
        .step_fwd (step_fwd),
        .step_rev (step_rev)
    );

    // Emission looks at pend plus this cycle's request so an idle emitter answers in one cycle.
    always_comb begin
        req  = step_fwd ? ONE : step_rev ? '1 : '0;
        sum  = {pend_q[PEND_W-1], pend_q} + req;
        dir  = (gap_q != '0 || sum == '0) ? DIR_NONE : sum[PEND_W] ? DIR_REV : DIR_FWD;
        emit = dir == DIR_FWD ? ONE : dir == DIR_REV ? '1 : '0;
        net  = sum - emit;
        drop = net > PMAX || net < -PMAX;
        keep = drop ? net - req : net;
        pend_d = keep[PEND_W-1:0];
`ifdef QEI_EMU_GLITCH_EN
        glitch = glitch_req && dir == DIR_NONE && gap_q == '0;
`else
        glitch = 1'b0;
`endif
        gap_d = (dir != DIR_NONE || glitch) ? GAP_W'(MIN_GAP - 1) : gap_q - GAP_W'(gap_q != '0);
        qstate_d = qei_next(qstate_q, dir);
        rev_d = dir == DIR_FWD ? (rev_q == REV_W'(CPR - 1) ? '0 : rev_q + 1'b1) :
                dir == DIR_REV ? (rev_q == '0 ? REV_W'(CPR - 1) : rev_q - 1'b1) : rev_q;
        pos_d = dir == DIR_FWD ? pos_q + 32'sd1 : dir == DIR_REV ? pos_q - 32'sd1 : pos_q;
        encab_d   = QEI_GRAY[qstate_d] ^ {1'b0, glitch};
        index_d   = rev_d == '0;
        overrun_d = drop || (overrun_q && !clr_overrun);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q    <= '0;
            gap_q     <= '0;
            qstate_q  <= '0;
            rev_q     <= '0;
            pos_q     <= '0;
            encab_q   <= 2'b00;
            index_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            gap_q     <= gap_d;
            qstate_q  <= qstate_d;
            rev_q     <= rev_d;
            pos_q     <= pos_d;
            encab_q   <= encab_d;
            index_q   <= index_d;
            overrun_q <= overrun_d;
        end
    end

    assign encab    = encab_q;
    assign index    = index_q;
    assign position = pos_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_qei_emulator.sv
// tb_qei_emulator: directed checks of edge timing, direction, index, saturation, reversal and reset.
module tb_qei_emulator;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] velocity = '0;
    logic        clr_overrun = 1'b0;
    logic [1:0]  encab;
    logic        index;
    logic signed [31:0] position;
    logic        overrun;
`ifdef QEI_EMU_GLITCH_EN
    logic        glitch_req = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    qei_emulator #(.ACC_W(32), .CPR(8), .MIN_GAP(4), .PEND_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .velocity    (velocity),
`ifdef QEI_EMU_GLITCH_EN
        .glitch_req  (glitch_req),
`endif
        .encab       (encab),
        .index       (index),
        .position    (position),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        enable = 1'b0;
        velocity = '0;
        clr_overrun = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int e;
        tick(2);
        check("rst_encab", encab, 2'b00);
        check("rst_index", index, 1);
        check("rst_pos", position, 0);
        check("rst_ovr", overrun, 0);

        // forward at 1/4 step per cycle: edge every 4 cycles, index each 8 edges
        do_reset();
        velocity = 32'h4000_0000;
        enable = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            tick(1);
            e = k / 4;
            check("fwd_encab", encab, gray[e % 4]);
            check("fwd_pos", position, e);
            check("fwd_index", index, (e % 8) == 0);
            check("fwd_ovr", overrun, 0);
        end

        // reverse at 1/16: first step at cycle 1, then every 16 cycles
        do_reset();
        velocity = -32'sh1000_0000;
        enable = 1'b1;
        for (int k = 1; k <= 49; k++) begin
            tick(1);
            e = (k + 15) / 16;
            check("rev_encab", encab, gray[(4 - e % 4) % 4]);
            check("rev_pos", position, -e);
            check("rev_index", index, (e % 8) == 0);
        end

        // overload: requests on odd cycles >= 3, edges every 4 cycles from 3; pend reaches 7 at 29
        do_reset();
        velocity = 32'h7FFF_FFFF;
        enable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick(1);
            check("sat_pos", position, n < 3 ? 0 : (n - 3) / 4 + 1);
            check("sat_ovr", overrun, (n == 33 || n >= 37) ? 1 : 0);
            if (n == 33) clr_overrun = 1'b1;
            if (n == 37) clr_overrun = 1'b0;
        end
        #2 reset_n = 1'b0;
        #1;
        check("arst_encab", encab, 2'b00);
        check("arst_pos", position, 0);
        check("arst_index", index, 1);
        check("arst_ovr", overrun, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // build pend=+3 by cycle 13, then flip velocity: rev requests cancel, one fwd drains
        do_reset();
        velocity = 32'h7FFF_FFFF;
        enable = 1'b1;
        tick(13);
        check("revs_pos13", position, 3);
        check("revs_enc13", encab, 2'b10);
        velocity = 32'h8000_0001;
        tick(1);
        check("revs_pos14", position, 3);
        tick(1);
        check("revs_pos15", position, 4);
        check("revs_enc15", encab, 2'b00);
        tick(3);
        check("revs_pos18", position, 4);
        tick(1);
        check("revs_pos19", position, 3);
        check("revs_enc19", encab, 2'b10);
        check("revs_ovr", overrun, 0);

`ifdef QEI_EMU_GLITCH_EN
        do_reset();
        velocity = '0;
        enable = 1'b1;
        tick(2);
        glitch_req = 1'b1;
        tick(1);
        check("glitch_on", encab, 2'b01);
        tick(1);
        glitch_req = 1'b0;
        check("glitch_off", encab, 2'b00);
        tick(1);
        check("glitch_hold", encab, 2'b00);
        check("glitch_pos", position, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
